player_life_manager: RTL and testbench

Owns the player's life point count and drives the `PlayerLifePoint` value consumed by the life-bar renderer. It accepts damage and heal events from game logic and applies saturating arithmetic. After each accepted hit it holds a frame-counted invulnerability window. Passive regeneration runs on a frame-counted schedule. The published life value changes only on `frame_tick`, so the renderer never sees a value change mid-scan.

---
 rtl/player_life_manager.sv | 137 +++++++++++++
 tb/tb_player_life_manager.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/player_life_manager.sv
// Player life bookkeeping: saturating damage/heal, frame-counted invulnerability
// and regeneration, with a life value that is republished only on frame_tick.
module player_life_manager #(
  parameter int MAX_PLAYER_LIFE_POINT = 100,
  parameter int INVULN_FRAMES         = 60,
  parameter int REGEN_PERIOD_FRAMES   = 120,
  parameter int REGEN_AMOUNT          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       hit_valid,
  input  logic [7:0] hit_damage,
  input  logic       heal_valid,
  input  logic [7:0] heal_amount,
  output logic [9:0] PlayerLifePoint,
  output logic       hit_ack,
  output logic       isInvulnerable,
  output logic       isDead
);

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

  localparam logic [9:0]  MAX_LIFE   = 10'(MAX_PLAYER_LIFE_POINT);
  localparam logic [15:0] INV_LOAD   = 16'(INVULN_FRAMES);
  localparam logic [15:0] REGEN_LAST = 16'(REGEN_PERIOD_FRAMES - 1);
  localparam logic [10:0] REGEN_ADD  = 11'(REGEN_AMOUNT);
  localparam logic        REGEN_ON   = (REGEN_PERIOD_FRAMES != 0);

  state_t      state, state_next;
  logic [9:0]  life_int, life_next;
  logic [15:0] inv_cnt, inv_next;
  logic [15:0] regen_cnt, regen_next;
  logic [9:0]  publish_next;
  logic        ack_next;

  logic        live;
  logic        hit_accept;
  logic [9:0]  after_hit;
  logic        dying;
  logic        heal_apply;
  logic [10:0] heal_sum;
  logic [9:0]  after_heal;
  logic        regen_tick;
  logic        regen_step;
  logic [10:0] regen_sum;
  logic [9:0]  after_regen;

  // Event pipeline within one cycle: hit first, then heal, then regen.
  assign live       = (state == ALIVE) || (state == INVULN);
  assign hit_accept = (state == ALIVE) && hit_valid && (hit_damage != 8'd0);
  assign after_hit  = !hit_accept                      ? life_int :
                      ({2'b00, hit_damage} >= life_int) ? 10'd0 :
                      life_int - {2'b00, hit_damage};
  assign dying      = hit_accept && (after_hit == 10'd0);
  assign heal_apply = heal_valid && !dying;
  assign heal_sum   = {1'b0, after_hit} + {3'b000, heal_amount};
  assign after_heal = !heal_apply                     ? after_hit :
                      (heal_sum > {1'b0, MAX_LIFE})   ? MAX_LIFE :
                      heal_sum[9:0];

  // Regen pacing looks at the life held before this cycle's events.
  assign regen_tick  = REGEN_ON && frame_tick && (life_int < MAX_LIFE) && !dying;
  assign regen_step  = regen_tick && (regen_cnt == REGEN_LAST);
  assign regen_sum   = {1'b0, after_heal} + REGEN_ADD;
  assign after_regen = !regen_step                   ? after_heal :
                       (regen_sum > {1'b0, MAX_LIFE}) ? MAX_LIFE :
                       regen_sum[9:0];

  assign isInvulnerable = (state == INVULN);
  assign isDead         = (state == DEAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      life_int        <= '0;
      inv_cnt         <= '0;
      regen_cnt       <= '0;
      PlayerLifePoint <= '0;
      hit_ack         <= 1'b0;
    end else begin
      state           <= state_next;
      life_int        <= life_next;
      inv_cnt         <= inv_next;
      regen_cnt       <= regen_next;
      PlayerLifePoint <= publish_next;
      hit_ack         <= ack_next;
    end
  end

  always_comb begin
    state_next   = state;
    life_next    = life_int;
    inv_next     = inv_cnt;
    regen_next   = regen_cnt;
    publish_next = PlayerLifePoint;
    ack_next     = 1'b0;

    if (start) begin
      state_next   = ALIVE;
      life_next    = MAX_LIFE;
      regen_next   = '0;
      publish_next = MAX_LIFE;
    end else begin
      if (frame_tick && (state != IDLE))
        publish_next = life_int;

      case (state)
        ALIVE: begin
          if (hit_accept) begin
            ack_next   = 1'b1;
            inv_next   = INV_LOAD;
            state_next = dying ? DEAD : INVULN;
          end
        end
        INVULN: begin
          if (frame_tick) begin
            inv_next = inv_cnt - 16'd1;
            if (inv_cnt == 16'd1)
              state_next = ALIVE;
          end
        end
        default: ;
      endcase

      if (live) begin
        life_next = after_regen;
        if (life_int >= MAX_LIFE || regen_step)
          regen_next = '0;
        else if (regen_tick)
          regen_next = regen_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_player_life_manager.sv
// Directed scoreboard bench for player_life_manager with default parameters
// (MAX 100, 60 invulnerable frames, regen +1 every 120 frames).
module tb_player_life_manager;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit_valid = 1'b0;
  logic [7:0] hit_damage = 8'd0;
  logic       heal_valid = 1'b0;
  logic [7:0] heal_amount = 8'd0;
  logic [9:0] PlayerLifePoint;
  logic       hit_ack;
  logic       isInvulnerable;
  logic       isDead;

  typedef struct {
    string      tag;
    logic [9:0] life;
    logic       ack;
    logic       inv;
    logic       dead;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  player_life_manager dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .frame_tick      (frame_tick),
    .hit_valid       (hit_valid),
    .hit_damage      (hit_damage),
    .heal_valid      (heal_valid),
    .heal_amount     (heal_amount),
    .PlayerLifePoint (PlayerLifePoint),
    .hit_ack         (hit_ack),
    .isInvulnerable  (isInvulnerable),
    .isDead          (isDead)
  );

  always #5 clk = ~clk;

  // Drive one clock of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic ft,
                               input logic hv, input logic [7:0] hd,
                               input logic lv, input logic [7:0] la);
    reset       = rst;
    start       = st;
    frame_tick  = ft;
    hit_valid   = hv;
    hit_damage  = hd;
    heal_valid  = lv;
    heal_amount = la;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    start       = 1'b0;
    frame_tick  = 1'b0;
    hit_valid   = 1'b0;
    hit_damage  = 8'd0;
    heal_valid  = 1'b0;
    heal_amount = 8'd0;
  endtask

  task automatic expectOut(input string tag, input logic [9:0] life,
                           input logic ack, input logic inv, input logic dead);
    exp_t e;
    e.tag  = tag;
    e.life = life;
    e.ack  = ack;
    e.inv  = inv;
    e.dead = dead;
    sb.push_back(e);
  endtask

  task automatic checkOutput;
    exp_t e;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      compared++;
      assert (PlayerLifePoint === e.life) else begin
        mismatched++;
        $error("[TB] FAIL %s.life: observed %0d expected %0d", e.tag, PlayerLifePoint, e.life);
      end
      compared++;
      assert (hit_ack === e.ack) else begin
        mismatched++;
        $error("[TB] FAIL %s.ack: observed %b expected %b", e.tag, hit_ack, e.ack);
      end
      compared++;
      assert (isInvulnerable === e.inv) else begin
        mismatched++;
        $error("[TB] FAIL %s.inv: observed %b expected %b", e.tag, isInvulnerable, e.inv);
      end
      compared++;
      assert (isDead === e.dead) else begin
        mismatched++;
        $error("[TB] FAIL %s.dead: observed %b expected %b", e.tag, isDead, e.dead);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st, input logic ft,
                      input logic hv, input logic [7:0] hd, input logic lv,
                      input logic [7:0] la, input logic [9:0] eLife,
                      input logic eAck, input logic eInv, input logic eDead);
    expectOut(tag, eLife, eAck, eInv, eDead);
    applyStimulus(rst, st, ft, hv, hd, lv, la);
    checkOutput();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //   tag                rst st ft hv hd    lv la     life ack inv dead
    step("reset",           1, 0, 0, 0, 8'd0,  0, 8'd0,  0,   0,  0,  0);
    step("start",           0, 1, 0, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);
    step("hit30",           0, 0, 0, 1, 8'd30, 0, 8'd0,  100, 1,  1,  0);
    step("ack_once",        0, 0, 0, 0, 8'd0,  0, 8'd0,  100, 0,  1,  0);
    step("hit_in_invuln",   0, 0, 0, 1, 8'd10, 0, 8'd0,  100, 0,  1,  0);
    step("pub70",           0, 0, 1, 0, 8'd0,  0, 8'd0,  70,  0,  1,  0);
    ticks(58);
    step("inv_tick59",      0, 0, 0, 0, 8'd0,  0, 8'd0,  70,  0,  1,  0);
    step("inv_end",         0, 0, 1, 0, 8'd0,  0, 8'd0,  70,  0,  0,  0);

    step("hit10_heal15",    0, 0, 0, 1, 8'd10, 1, 8'd15, 70,  1,  1,  0);
    step("pub75",           0, 0, 1, 0, 8'd0,  0, 8'd0,  75,  0,  1,  0);
    step("heal20_a",        0, 0, 0, 0, 8'd0,  1, 8'd20, 75,  0,  1,  0);
    step("heal20_sat",      0, 0, 0, 0, 8'd0,  1, 8'd20, 75,  0,  1,  0);
    step("pub100",          0, 0, 1, 0, 8'd0,  0, 8'd0,  100, 0,  1,  0);
    ticks(58);
    step("back_alive",      0, 0, 0, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);
    step("hit_zero",        0, 0, 0, 1, 8'd0,  0, 8'd0,  100, 0,  0,  0);

    // Regeneration from 98: one step per 120 frames.
    step("hit2",            0, 0, 0, 1, 8'd2,  0, 8'd0,  100, 1,  1,  0);
    ticks(119);
    step("regen_t120",      0, 0, 1, 0, 8'd0,  0, 8'd0,  98,  0,  0,  0);
    step("regen_t121",      0, 0, 1, 0, 8'd0,  0, 8'd0,  99,  0,  0,  0);
    ticks(118);
    step("regen_t240",      0, 0, 1, 0, 8'd0,  0, 8'd0,  99,  0,  0,  0);
    step("regen_t241",      0, 0, 1, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);
    ticks(50);
    step("hit1",            0, 0, 0, 1, 8'd1,  0, 8'd0,  100, 1,  1,  0);
    ticks(119);
    step("hold_t120",       0, 0, 1, 0, 8'd0,  0, 8'd0,  99,  0,  0,  0);
    step("hold_t121",       0, 0, 1, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);

    // Lethal hit with a same-cycle heal, then events while dead.
    step("hit80",           0, 0, 0, 1, 8'd80, 0, 8'd0,  100, 1,  1,  0);
    ticks(60);
    step("alive20",         0, 0, 0, 0, 8'd0,  0, 8'd0,  20,  0,  0,  0);
    step("hit_kill",        0, 0, 0, 1, 8'd200,1, 8'd50, 20,  1,  0,  1);
    step("pub_dead",        0, 0, 1, 0, 8'd0,  0, 8'd0,  0,   0,  0,  1);
    step("dead_events",     0, 0, 0, 1, 8'd5,  1, 8'd50, 0,   0,  0,  1);
    step("dead_tick",       0, 0, 1, 0, 8'd0,  0, 8'd0,  0,   0,  0,  1);

    step("restart",         0, 1, 0, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);
    step("start_over_hit",  0, 1, 0, 1, 8'd30, 1, 8'd5,  100, 0,  0,  0);
    step("start_tick",      0, 0, 1, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);
    step("hit30_b",         0, 0, 0, 1, 8'd30, 0, 8'd0,  100, 1,  1,  0);
    step("reset_wins",      1, 1, 0, 1, 8'd30, 0, 8'd0,  0,   0,  0,  0);
    step("idle_hit",        0, 0, 0, 1, 8'd30, 0, 8'd0,  0,   0,  0,  0);
    step("idle_tick",       0, 0, 1, 0, 8'd0,  0, 8'd0,  0,   0,  0,  0);
    step("start_after_idle",0, 1, 0, 0, 8'd0,  0, 8'd0,  100, 0,  0,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
